// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - 3-wide reorder buffer with in-order allocation and up-to-3-per-cycle commit
module rob_commit #(
    parameter int DEPTH  = 16,
    parameter int AREG_W = 3,
    parameter int PREG_W = 4,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_issue_x,
    input  logic              valid_issue_y,
    input  logic              valid_issue_z,
    input  logic              freeze_front,
    input  logic [AREG_W-1:0] areg_x,
    input  logic [AREG_W-1:0] areg_y,
    input  logic [AREG_W-1:0] areg_z,
    input  logic [PREG_W-1:0] preg_x,
    input  logic [PREG_W-1:0] preg_y,
    input  logic [PREG_W-1:0] preg_z,
    output logic [TAG_W-1:0]  tag_x,
    output logic [TAG_W-1:0]  tag_y,
    output logic [TAG_W-1:0]  tag_z,
    input  logic              wb_valid_add,
    input  logic              wb_valid_mul,
    input  logic [TAG_W-1:0]  wb_tag_add,
    input  logic [TAG_W-1:0]  wb_tag_mul,
    input  logic              wb_exp_add,
    input  logic              wb_exp_mul,
    output logic              RegWr_x,
    output logic              RegWr_y,
    output logic              RegWr_z,
    output logic              exp_x,
    output logic              exp_y,
    output logic              exp_z,
    output logic [AREG_W-1:0] cmt_areg_x,
    output logic [AREG_W-1:0] cmt_areg_y,
    output logic [AREG_W-1:0] cmt_areg_z,
    output logic [PREG_W-1:0] cmt_preg_x,
    output logic [PREG_W-1:0] cmt_preg_y,
    output logic [PREG_W-1:0] cmt_preg_z,
    input  logic              flush,
    output logic              full_ROB,
    output logic [TAG_W:0]    count
);

    logic [DEPTH-1:0]  ent_valid, ent_done, ent_exp;
    logic [AREG_W-1:0] ent_areg [DEPTH];
    logic [PREG_W-1:0] ent_preg [DEPTH];
    logic [TAG_W-1:0]  head, tail;
    logic [TAG_W:0]    count_q;

    logic              alloc_en;
    logic [TAG_W-1:0]  pos_y, pos_z;
    logic [TAG_W:0]    n_alloc, n_commit;
    logic [TAG_W-1:0]  h0, h1, h2;
    logic              cx, cy, cz;

    // Valid lanes are packed onto consecutive slots starting at tail.
    assign alloc_en = !freeze_front && !flush;
    assign pos_y    = tail + TAG_W'(valid_issue_x);
    assign pos_z    = pos_y + TAG_W'(valid_issue_y);
    assign n_alloc  = alloc_en ? (TAG_W+1)'(valid_issue_x) + (TAG_W+1)'(valid_issue_y)
                               + (TAG_W+1)'(valid_issue_z) : '0;

    // An idle lane shows its uncompacted slot so an idle ROB reports tail, tail+1, tail+2.
    assign tag_x = tail;
    assign tag_y = valid_issue_y ? pos_y : tail + TAG_W'(1);
    assign tag_z = valid_issue_z ? pos_z : tail + TAG_W'(2);

    assign h0 = head;
    assign h1 = head + TAG_W'(1);
    assign h2 = head + TAG_W'(2);

    assign count    = count_q;
    assign full_ROB = count_q > (TAG_W+1)'(DEPTH - 3);

    // Commit chain: each lane needs the previous lane to retire without an exception.
    always_comb begin
        cx = !flush && ent_valid[h0] && ent_done[h0];
        cy = cx && !ent_exp[h0] && ent_valid[h1] && ent_done[h1];
        cz = cy && !ent_exp[h1] && ent_valid[h2] && ent_done[h2];
        n_commit   = (TAG_W+1)'(cx) + (TAG_W+1)'(cy) + (TAG_W+1)'(cz);
        RegWr_x    = cx;
        RegWr_y    = cy;
        RegWr_z    = cz;
        exp_x      = cx && ent_exp[h0];
        exp_y      = cy && ent_exp[h1];
        exp_z      = cz && ent_exp[h2];
        cmt_areg_x = cx ? ent_areg[h0] : '0;
        cmt_areg_y = cy ? ent_areg[h1] : '0;
        cmt_areg_z = cz ? ent_areg[h2] : '0;
        cmt_preg_x = cx ? ent_preg[h0] : '0;
        cmt_preg_y = cy ? ent_preg[h1] : '0;
        cmt_preg_z = cz ? ent_preg[h2] : '0;
    end

    // Entry status and pointers: retire, record writebacks, then allocate into free slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            ent_done  <= '0;
            ent_exp   <= '0;
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
        end else begin
            if (cx) ent_valid[h0] <= 1'b0;
            if (cy) ent_valid[h1] <= 1'b0;
            if (cz) ent_valid[h2] <= 1'b0;
            if (wb_valid_add && ent_valid[wb_tag_add]) begin
                ent_done[wb_tag_add] <= 1'b1;
                ent_exp[wb_tag_add]  <= wb_exp_add;
            end
            if (wb_valid_mul && ent_valid[wb_tag_mul]) begin
                ent_done[wb_tag_mul] <= 1'b1;
                ent_exp[wb_tag_mul]  <= wb_exp_mul;
            end
            if (alloc_en && valid_issue_x) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                ent_exp[tail]   <= 1'b0;
            end
            if (alloc_en && valid_issue_y) begin
                ent_valid[pos_y] <= 1'b1;
                ent_done[pos_y]  <= 1'b0;
                ent_exp[pos_y]   <= 1'b0;
            end
            if (alloc_en && valid_issue_z) begin
                ent_valid[pos_z] <= 1'b1;
                ent_done[pos_z]  <= 1'b0;
                ent_exp[pos_z]   <= 1'b0;
            end
            head    <= head + TAG_W'(n_commit);
            tail    <= tail + TAG_W'(n_alloc);
            count_q <= count_q + n_alloc - n_commit;
        end
    end

    // Destination payload is only meaningful while the entry is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_en && valid_issue_x) begin
            ent_areg[tail] <= areg_x;
            ent_preg[tail] <= preg_x;
        end
        if (alloc_en && valid_issue_y) begin
            ent_areg[pos_y] <= areg_y;
            ent_preg[pos_y] <= preg_y;
        end
        if (alloc_en && valid_issue_z) begin
            ent_areg[pos_z] <= areg_z;
            ent_preg[pos_z] <= preg_z;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - scoreboard bench for rob_commit with a queue-based reference model
module tb_rob_commit;

    localparam int DEPTH  = 8;
    localparam int AREG_W = 3;
    localparam int PREG_W = 4;
    localparam int TAG_W  = 3;

    logic clk, rst;
    logic valid_issue_x, valid_issue_y, valid_issue_z, freeze_front, flush;
    logic [AREG_W-1:0] areg_x, areg_y, areg_z;
    logic [PREG_W-1:0] preg_x, preg_y, preg_z;
    logic [TAG_W-1:0]  tag_x, tag_y, tag_z;
    logic wb_valid_add, wb_valid_mul, wb_exp_add, wb_exp_mul;
    logic [TAG_W-1:0]  wb_tag_add, wb_tag_mul;
    logic RegWr_x, RegWr_y, RegWr_z, exp_x, exp_y, exp_z, full_ROB;
    logic [AREG_W-1:0] cmt_areg_x, cmt_areg_y, cmt_areg_z;
    logic [PREG_W-1:0] cmt_preg_x, cmt_preg_y, cmt_preg_z;
    logic [TAG_W:0]    count;

    rob_commit #(.DEPTH(DEPTH), .AREG_W(AREG_W), .PREG_W(PREG_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .valid_issue_x(valid_issue_x), .valid_issue_y(valid_issue_y), .valid_issue_z(valid_issue_z),
        .freeze_front(freeze_front),
        .areg_x(areg_x), .areg_y(areg_y), .areg_z(areg_z),
        .preg_x(preg_x), .preg_y(preg_y), .preg_z(preg_z),
        .tag_x(tag_x), .tag_y(tag_y), .tag_z(tag_z),
        .wb_valid_add(wb_valid_add), .wb_valid_mul(wb_valid_mul),
        .wb_tag_add(wb_tag_add), .wb_tag_mul(wb_tag_mul),
        .wb_exp_add(wb_exp_add), .wb_exp_mul(wb_exp_mul),
        .RegWr_x(RegWr_x), .RegWr_y(RegWr_y), .RegWr_z(RegWr_z),
        .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
        .cmt_areg_x(cmt_areg_x), .cmt_areg_y(cmt_areg_y), .cmt_areg_z(cmt_areg_z),
        .cmt_preg_x(cmt_preg_x), .cmt_preg_y(cmt_preg_y), .cmt_preg_z(cmt_preg_z),
        .flush(flush), .full_ROB(full_ROB), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          tag;
        logic [2:0]  areg;
        logic [3:0]  preg;
    } ent_t;

    ent_t sbq[$];
    bit   done_m [DEPTH];
    bit   exp_m  [DEPTH];
    int   m_tail;
    bit   mon_en;
    bit   exc_pending;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        valid_issue_x = 0; valid_issue_y = 0; valid_issue_z = 0;
        freeze_front = 0; flush = 0;
        areg_x = 0; areg_y = 0; areg_z = 0;
        preg_x = 0; preg_y = 0; preg_z = 0;
        wb_valid_add = 0; wb_valid_mul = 0; wb_tag_add = 0; wb_tag_mul = 0;
        wb_exp_add = 0; wb_exp_mul = 0;
    endtask

    // One cycle: check allocation tags, advance the model at the clock edge, return idle.
    task automatic step();
        int k;
        if (exc_pending) begin
            flush = 1;
            exc_pending = 0;
        end
        #1;
        k = 0;
        if (valid_issue_x) begin chk("tag_x", 32'(tag_x), 32'((m_tail + k) % DEPTH)); k++; end
        if (valid_issue_y) begin chk("tag_y", 32'(tag_y), 32'((m_tail + k) % DEPTH)); k++; end
        if (valid_issue_z) begin chk("tag_z", 32'(tag_z), 32'((m_tail + k) % DEPTH)); k++; end
        @(posedge clk);
        if (flush) begin
            sbq.delete();
            m_tail = 0;
        end else begin
            if (wb_valid_add) begin done_m[wb_tag_add] = 1; exp_m[wb_tag_add] = wb_exp_add; end
            if (wb_valid_mul) begin done_m[wb_tag_mul] = 1; exp_m[wb_tag_mul] = wb_exp_mul; end
            if (!freeze_front) begin
                if (valid_issue_x) begin
                    sbq.push_back('{m_tail, areg_x, preg_x}); done_m[m_tail] = 0; m_tail = (m_tail + 1) % DEPTH;
                end
                if (valid_issue_y) begin
                    sbq.push_back('{m_tail, areg_y, preg_y}); done_m[m_tail] = 0; m_tail = (m_tail + 1) % DEPTH;
                end
                if (valid_issue_z) begin
                    sbq.push_back('{m_tail, areg_z, preg_z}); done_m[m_tail] = 0; m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        #1;
        idle_inputs();
    endtask

    // Monitor: expected retirement is the oldest done entries, up to 3, ending at the first exception.
    always @(negedge clk) begin
        int   n;
        bit   stop;
        logic rw [3];
        logic ex [3];
        logic [AREG_W-1:0] ar [3];
        logic [PREG_W-1:0] pr [3];
        if (mon_en) begin
            rw[0] = RegWr_x; rw[1] = RegWr_y; rw[2] = RegWr_z;
            ex[0] = exp_x;   ex[1] = exp_y;   ex[2] = exp_z;
            ar[0] = cmt_areg_x; ar[1] = cmt_areg_y; ar[2] = cmt_areg_z;
            pr[0] = cmt_preg_x; pr[1] = cmt_preg_y; pr[2] = cmt_preg_z;
            chk("count", 32'(count), 32'(sbq.size()));
            chk("full_ROB", 32'(full_ROB), 32'(sbq.size() > DEPTH - 3));
            n = 0;
            stop = 0;
            if (!flush) begin
                for (int i = 0; i < 3; i++) begin
                    if (!stop) begin
                        if (i < sbq.size() && done_m[sbq[i].tag]) begin
                            n++;
                            if (exp_m[sbq[i].tag]) stop = 1;
                        end else begin
                            stop = 1;
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("RegWr_lane%0d", i), 32'(rw[i]), 32'(i < n));
                if (i < n) begin
                    chk($sformatf("exp_lane%0d", i), 32'(ex[i]), 32'(exp_m[sbq[i].tag]));
                    chk($sformatf("cmt_areg_lane%0d", i), 32'(ar[i]), 32'(sbq[i].areg));
                    chk($sformatf("cmt_preg_lane%0d", i), 32'(pr[i]), 32'(sbq[i].preg));
                end
            end
            if (n > 0 && exp_m[sbq[n-1].tag]) exc_pending = 1;
            for (int i = 0; i < n; i++) void'(sbq.pop_front());
        end
    end

    task automatic dispatch3(input int p0, input int p1, input int p2);
        valid_issue_x = 1; valid_issue_y = 1; valid_issue_z = 1;
        areg_x = 3'(p0); areg_y = 3'(p1); areg_z = 3'(p2);
        preg_x = 4'(p0 + 4); preg_y = 4'(p1 + 4); preg_z = 4'(p2 + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pend[$];
        int a, b;
        n_checks = 0; n_fail = 0; m_tail = 0; mon_en = 0; exc_pending = 0;
        for (int i = 0; i < DEPTH; i++) begin done_m[i] = 0; exp_m[i] = 0; end
        idle_inputs();
        rst = 0;
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_full", 32'(full_ROB), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("idle_tag_x", 32'(tag_x), 0);
        chk("idle_tag_y", 32'(tag_y), 1);
        chk("idle_tag_z", 32'(tag_z), 2);
        chk("idle_regwr", 32'({RegWr_x, RegWr_y, RegWr_z}), 0);
        mon_en = 1;
        @(posedge clk); #1;

        // Out-of-order writeback 2,0,1 retires strictly in order.
        dispatch3(1, 2, 3); step();
        wb_valid_add = 1; wb_tag_add = 2; step();
        wb_valid_add = 1; wb_tag_add = 0; #1;
        chk("no_commit_before_head", 32'(RegWr_x), 0);
        step();
        wb_valid_mul = 1; wb_tag_mul = 1; #1;
        chk("head_commit_x", 32'(RegWr_x), 1);
        chk("head_commit_preg", 32'(cmt_preg_x), 5);
        chk("head_commit_y_off", 32'(RegWr_y), 0);
        step();
        #1;
        chk("pair_commit", 32'({RegWr_x, RegWr_y, RegWr_z}), 32'b110);
        chk("pair_preg_x", 32'(cmt_preg_x), 6);
        chk("pair_preg_y", 32'(cmt_preg_y), 7);
        step();

        // Lane y absent: x and z are packed onto consecutive tags.
        flush = 1; step();
        valid_issue_x = 1; valid_issue_z = 1; areg_x = 5; preg_x = 9; areg_z = 6; preg_z = 10; #1;
        chk("compact_tag_x", 32'(tag_x), 0);
        chk("compact_tag_z", 32'(tag_z), 1);
        step();
        #1 chk("compact_count", 32'(count), 2);

        // Exception on tag 1 stops the chain; flush then empties the ROB.
        flush = 1; step();
        dispatch3(0, 1, 2); step();
        wb_valid_add = 1; wb_tag_add = 2; step();
        wb_valid_add = 1; wb_tag_add = 0; wb_valid_mul = 1; wb_tag_mul = 1; wb_exp_mul = 1; step();
        #1;
        chk("exc_regwr", 32'({RegWr_x, RegWr_y, RegWr_z}), 32'b110);
        chk("exc_exp", 32'({exp_x, exp_y, exp_z}), 32'b010);
        step();
        flush = 1; #1;
        chk("flush_regwr", 32'({RegWr_x, RegWr_y, RegWr_z}), 0);
        chk("flush_exp", 32'({exp_x, exp_y, exp_z}), 0);
        step();
        #1;
        chk("post_flush_count", 32'(count), 0);
        chk("post_flush_tag_x", 32'(tag_x), 0);

        // Six of eight occupied raises full; one retirement drops it.
        flush = 1; step();
        dispatch3(1, 2, 3); step();
        dispatch3(4, 5, 6); step();
        #1;
        chk("fill_count", 32'(count), 6);
        chk("fill_full", 32'(full_ROB), 1);
        wb_valid_add = 1; wb_tag_add = 0; step();
        step();
        #1;
        chk("drain_full", 32'(full_ROB), 0);
        chk("drain_count", 32'(count), 5);

        // Randomised traffic: head and tail wrap many times.
        flush = 1; step();
        for (int cyc = 0; cyc < 400; cyc++) begin
            freeze_front = (sbq.size() > DEPTH - 3) || ($urandom_range(0, 7) == 0);
            valid_issue_x = 1'($urandom); valid_issue_y = 1'($urandom); valid_issue_z = 1'($urandom);
            areg_x = 3'($urandom); areg_y = 3'($urandom); areg_z = 3'($urandom);
            preg_x = 4'($urandom); preg_y = 4'($urandom); preg_z = 4'($urandom);
            pend.delete();
            foreach (sbq[i]) if (!done_m[sbq[i].tag]) pend.push_back(sbq[i].tag);
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                a = $urandom_range(0, pend.size() - 1);
                wb_valid_add = 1; wb_tag_add = 3'(pend[a]); wb_exp_add = ($urandom_range(0, 11) == 0);
                if (pend.size() > 1 && $urandom_range(0, 1) == 1) begin
                    b = (a + 1 + $urandom_range(0, pend.size() - 2)) % pend.size();
                    wb_valid_mul = 1; wb_tag_mul = 3'(pend[b]); wb_exp_mul = ($urandom_range(0, 11) == 0);
                end
            end
            if ($urandom_range(0, 59) == 0) flush = 1;
            step();
        end

        // Asynchronous reset in the middle of a burst.
        if (!(sbq.size() > DEPTH - 3)) dispatch3(1, 2, 3);
        step();
        mon_en = 0;
        #2 rst = 0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_full", 32'(full_ROB), 0);
        chk("async_rst_regwr", 32'({RegWr_x, RegWr_y, RegWr_z}), 0);
        chk("async_rst_exp", 32'({exp_x, exp_y, exp_z}), 0);
        chk("async_rst_tags", 32'({tag_x, tag_y, tag_z}), 32'({3'd0, 3'd1, 3'd2}));
        repeat (2) @(posedge clk);
        #1 rst = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
